filter_arbiter: RTL and testbench

- Sits directly downstream of NUM_FILTER filter-logic instances inside a filter bank; feeds one force pipeline.
- Each cycle, grants at most one filter with a non-empty output buffer, using round-robin order.
- Pulses that filter's read-select and captures the popped pair {ref_id, neighbor_id, r2, dz, dy, dx} one cycle later.
- Presents the pair to the force pipeline with a valid strobe and counts dispatched pairs.

---
 rtl/filter_arbiter.sv | 104 ++++++++++
 tb/tb_filter_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_arbiter.sv
// Round-robin arbiter draining NUM_FILTER filter output buffers into one
// force pipeline: one-hot read select, pop capture, valid strobe, pair count.
module filter_arbiter #(
    parameter int NUM_FILTER        = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 20,
    parameter int PAIR_COUNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_FILTER-1:0]         pair_available,
    input  logic [NUM_FILTER*(2*PARTICLE_ID_WIDTH+4*DATA_WIDTH)-1:0] pair_data,
    output logic [NUM_FILTER-1:0]         sel,
    output logic [PARTICLE_ID_WIDTH-1:0]  ref_particle_id_out,
    output logic [PARTICLE_ID_WIDTH-1:0]  neighbor_particle_id_out,
    output logic [DATA_WIDTH-1:0]         r2_out,
    output logic [DATA_WIDTH-1:0]         dx_out,
    output logic [DATA_WIDTH-1:0]         dy_out,
    output logic [DATA_WIDTH-1:0]         dz_out,
    output logic                          out_valid,
    output logic [PAIR_COUNT_WIDTH-1:0]   pair_count,
    output logic                          idle
);

    localparam int PW = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH;
    localparam int IW = $clog2(NUM_FILTER);
    localparam int DW = DATA_WIDTH;

    logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]               gidx_q, gidx_d;
    logic                        gvalid_q, gvalid_d;
    logic [PW-1:0]               pair_q, pair_d;
    logic                        out_valid_q, out_valid_d;
    logic [PAIR_COUNT_WIDTH-1:0] count_q, count_d;

    logic [2*NUM_FILTER-1:0] dbl;
    logic [NUM_FILTER-1:0]   rot;
    logic [IW-1:0]           off;
    logic [IW:0]             sum;
    logic [IW-1:0]           grant_idx;
    logic                    found;
    logic                    grant;

    // Rotate requests so the scan starts at rr_ptr, then map back.
    always_comb begin
        dbl   = {pair_available, pair_available};
        rot   = NUM_FILTER'(dbl >> rr_ptr_q);
        found = |rot;
        off   = '0;
        for (int k = NUM_FILTER-1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        if (sum >= (IW+1)'(NUM_FILTER)) sum = sum - (IW+1)'(NUM_FILTER);
        grant_idx = sum[IW-1:0];
    end

    assign grant = rst & enable & found;
    assign sel   = grant ? (NUM_FILTER'(1) << grant_idx) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (grant_idx == IW'(NUM_FILTER-1)) ? '0
                                                       : grant_idx + 1'b1;
        end
        gidx_d      = grant_idx;
        gvalid_d    = grant;
        pair_d      = gvalid_q ? pair_data[int'(gidx_q)*PW +: PW] : '0;
        out_valid_d = gvalid_q;
        count_d     = count_q + PAIR_COUNT_WIDTH'(gvalid_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            gvalid_q    <= 1'b0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            gidx_q      <= gidx_d;
            gvalid_q    <= gvalid_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign dx_out     = pair_q[DW-1:0];
    assign dy_out     = pair_q[2*DW-1:DW];
    assign dz_out     = pair_q[3*DW-1:2*DW];
    assign r2_out     = pair_q[4*DW-1:3*DW];
    assign neighbor_particle_id_out = pair_q[4*DW+PARTICLE_ID_WIDTH-1:4*DW];
    assign ref_particle_id_out      = pair_q[PW-1:4*DW+PARTICLE_ID_WIDTH];
    assign out_valid  = out_valid_q;
    assign pair_count = count_q;
    // Held in reset, nothing can be granted, so report idle.
    assign idle = ~rst | (~gvalid_q & ~out_valid_q & ~|pair_available);

endmodule

// File: tb/tb_filter_arbiter.sv
// Directed self-checking bench for filter_arbiter.
// Linear stimulus; expected values worked out by hand per step.
module tb_filter_arbiter;

    localparam int NF = 4;
    localparam int DW = 32;
    localparam int IDW = 20;
    localparam int CW = 32;
    localparam int PW = 2*IDW + 4*DW;

    logic            clk;
    logic            rst;
    logic            enable;
    logic [NF-1:0]   pair_available;
    logic [NF*PW-1:0] pair_data;
    logic [NF-1:0]   sel;
    logic [IDW-1:0]  ref_o;
    logic [IDW-1:0]  nbr_o;
    logic [DW-1:0]   r2_o, dx_o, dy_o, dz_o;
    logic            out_valid;
    logic [CW-1:0]   pair_count;
    logic            idle;

    int checks = 0;
    int errors = 0;

    filter_arbiter #(
        .NUM_FILTER(NF),
        .DATA_WIDTH(DW),
        .PARTICLE_ID_WIDTH(IDW),
        .PAIR_COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .pair_available(pair_available),
        .pair_data(pair_data),
        .sel(sel),
        .ref_particle_id_out(ref_o),
        .neighbor_particle_id_out(nbr_o),
        .r2_out(r2_o),
        .dx_out(dx_o),
        .dy_out(dy_o),
        .dz_out(dz_o),
        .out_valid(out_valid),
        .pair_count(pair_count),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int i, input logic [IDW-1:0] r,
                             input logic [IDW-1:0] n, input logic [DW-1:0] r2,
                             input logic [DW-1:0] dz, input logic [DW-1:0] dy,
                             input logic [DW-1:0] dx);
        pair_data[i*PW +: PW] = {r, n, r2, dz, dy, dx};
    endtask

    task automatic set_default(input int i);
        set_slice(i, IDW'(32'h100 + i), IDW'(32'h200 + i), 32'h3F800000 + i,
                  32'h30 + i, 32'h20 + i, 32'h10 + i);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b1;
        pair_available = 4'b1111;
        pair_data = '0;
        for (int i = 0; i < NF; i++) set_default(i);

        // Reset held with everything available
        repeat (3) tick();
        #1;
        check("rst_sel", 64'(sel), 64'h0);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_count", 64'(pair_count), 64'h0);
        check("rst_idle", 64'(idle), 64'h1);
        check("rst_ref", 64'(ref_o), 64'h0);
        rst = 1'b1;
        #1;
        check("first_sel", 64'(sel), 64'h1);
        enable = 1'b0;
        pair_available = 4'b0000;
        #1;
        check("disabled_sel", 64'(sel), 64'h0);
        tick();
        check("quiet_valid", 64'(out_valid), 64'h0);
        check("quiet_idle", 64'(idle), 64'h1);

        // Single pair from filter 2
        enable = 1'b1;
        pair_available = 4'b0100;
        set_slice(2, 20'd5, 20'd9, 32'h42C80000, 32'h3, 32'h2, 32'h1);
        #1;
        check("single_sel", 64'(sel), 64'h4);
        tick();
        pair_available = 4'b0000;
        #1;
        check("single_n1_valid", 64'(out_valid), 64'h0);
        check("single_n1_idle", 64'(idle), 64'h0);
        tick();
        check("single_valid", 64'(out_valid), 64'h1);
        check("single_ref", 64'(ref_o), 64'd5);
        check("single_nbr", 64'(nbr_o), 64'd9);
        check("single_r2", 64'(r2_o), 64'h42C80000);
        check("single_dz", 64'(dz_o), 64'h3);
        check("single_dy", 64'(dy_o), 64'h2);
        check("single_dx", 64'(dx_o), 64'h1);
        check("single_count", 64'(pair_count), 64'd1);
        tick();
        check("single_drop_valid", 64'(out_valid), 64'h0);
        check("single_drop_ref", 64'(ref_o), 64'h0);
        check("single_drop_r2", 64'(r2_o), 64'h0);
        check("single_idle", 64'(idle), 64'h1);
        set_default(2);

        // Skip and wrap: pointer at 3, filters 0 and 1 available
        pair_available = 4'b0011;
        #1;
        check("wrap_sel0", 64'(sel), 64'h1);
        tick();
        check("wrap_sel1", 64'(sel), 64'h2);
        tick();
        pair_available = 4'b0000;
        #1;
        check("wrap_valid0", 64'(out_valid), 64'h1);
        check("wrap_ref0", 64'(ref_o), 64'h100);
        tick();
        check("wrap_valid1", 64'(out_valid), 64'h1);
        check("wrap_ref1", 64'(ref_o), 64'h101);
        check("wrap_count", 64'(pair_count), 64'd3);

        // Round robin with all four available for 8 cycles, pointer at 2
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            pair_available = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8)
                check($sformatf("rr_sel%0d", c), 64'(sel),
                      64'(4'b0001 << ((2 + c) % 4)));
            if (c >= 2) begin
                check($sformatf("rr_valid%0d", c), 64'(out_valid), 64'h1);
                check($sformatf("rr_ref%0d", c), 64'(ref_o),
                      64'h100 + 64'(c % 4));
                check($sformatf("rr_dx%0d", c), 64'(dx_o),
                      64'h10 + 64'(c % 4));
            end
        end
        tick();
        check("rr_end_valid", 64'(out_valid), 64'h0);
        check("rr_count", 64'(pair_count), 64'd11);

        // Enable low for three cycles mid-stream, pointer at 2
        pair_available = 4'b1111;
        #1;
        check("en_sel0", 64'(sel), 64'h4);
        tick();
        check("en_sel1", 64'(sel), 64'h8);
        tick();
        enable = 1'b0;
        #1;
        check("en_off_sel0", 64'(sel), 64'h0);
        check("en_off_valid0", 64'(out_valid), 64'h1);
        check("en_off_ref0", 64'(ref_o), 64'h102);
        tick();
        check("en_off_sel1", 64'(sel), 64'h0);
        check("en_off_valid1", 64'(out_valid), 64'h1);
        check("en_off_ref1", 64'(ref_o), 64'h103);
        tick();
        check("en_off_sel2", 64'(sel), 64'h0);
        check("en_off_valid2", 64'(out_valid), 64'h0);
        tick();
        enable = 1'b1;
        #1;
        check("en_resume_sel0", 64'(sel), 64'h1);
        check("en_resume_valid", 64'(out_valid), 64'h0);
        tick();
        check("en_resume_sel1", 64'(sel), 64'h2);
        tick();
        pair_available = 4'b0000;
        #1;
        check("en_out_valid0", 64'(out_valid), 64'h1);
        check("en_out_ref0", 64'(ref_o), 64'h100);
        tick();
        check("en_out_ref1", 64'(ref_o), 64'h101);
        tick();
        check("en_end_valid", 64'(out_valid), 64'h0);
        check("en_count", 64'(pair_count), 64'd15);

        // Async reset while pairs are in flight, pointer at 2
        pair_available = 4'b1111;
        #1;
        check("ar_sel0", 64'(sel), 64'h4);
        tick();
        check("ar_sel1", 64'(sel), 64'h8);
        tick();
        pair_available = 4'b0000;
        #1;
        check("ar_pre_valid", 64'(out_valid), 64'h1);
        check("ar_pre_count", 64'(pair_count), 64'd16);
        #1;
        rst = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'h0);
        check("ar_count", 64'(pair_count), 64'h0);
        check("ar_ref", 64'(ref_o), 64'h0);
        check("ar_idle", 64'(idle), 64'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("ar_post_valid0", 64'(out_valid), 64'h0);
        tick();
        check("ar_post_valid1", 64'(out_valid), 64'h0);
        check("ar_post_count", 64'(pair_count), 64'h0);
        check("ar_post_idle", 64'(idle), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
